// File: rtl/rca_seq_ctrl.sv
// Wide adder sequencer: drives one shared 4-bit ripple-carry adder one nibble per clock, LSB first.
// Define RCA_SEQ_SUB_EN to add the sub port (two's-complement subtraction through the same adder).
module rca_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
`ifdef RCA_SEQ_SUB_EN
    input  logic                 sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 busy,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             cin_q;
    logic             sub_q;
    logic             carry_q;
    logic [3:0]       b_nib;

`ifndef RCA_SEQ_SUB_EN
    assign sub_q = 1'b0;
`endif

    // Ready drops immediately while reset is held, independent of the state register.
    assign in_ready = rst_n && (state == IDLE);

    assign b_nib = b_q[{idx, 2'b00} +: 4];

    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_q[{idx, 2'b00} +: 4];
            add_b   = sub_q ? ~b_nib : b_nib;
            add_cin = (idx == '0) ? (sub_q | cin_q) : carry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry_q   <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        cin_q <= cin;
`ifdef RCA_SEQ_SUB_EN
                        sub_q <= sub;
`endif
                        idx   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[{idx, 2'b00} +: 4] <= add_sum;
                    carry_q                <= add_cout;
                    idx                    <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout      <= add_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl: models the shared 4-bit adder and checks results against plain W-bit arithmetic.
module tb_rca_seq_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;
`ifdef RCA_SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;
    logic [4:0]   adder_res;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] seq_a [16];
    logic       seq_c [16];

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;
        logic         vs;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;
    vec_t vt[$];

    always #5 clk = ~clk;

    assign adder_res = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    assign add_sum   = adder_res[3:0];
    assign add_cout  = adder_res[4];

    rca_seq_ctrl #(.NIBBLES(NIB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cin(cin),
`ifdef RCA_SEQ_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout),
        .busy(busy),
        .add_a(add_a),
        .add_b(add_b),
        .add_cin(add_cin),
        .add_sum(add_sum),
        .add_cout(add_cout)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        if (SUB_EN && s)
            return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge after the result handshake.
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                      input logic ts, input string nm,
                      output logic [W-1:0] rs, output logic rc);
        int k;
        a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1;
        #1;
        chk({nm, " in_ready"}, 64'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = ~cin; sub = ~sub;
        k = 0;
        while (!out_valid && k < 50) begin
            if (k < 16) begin
                seq_a[k] = add_a;
                seq_c[k] = add_cin;
            end
            @(negedge clk);
            k++;
        end
        chk({nm, " latency"}, 64'(k), NIB);
        rs = sum;
        rc = cout;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " out_valid after handshake"}, 64'(out_valid), 0);
        chk({nm, " in_ready after handshake"}, 64'(in_ready), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rs;
        logic         rc;
        logic [W:0]   exp;
        logic [3:0]   exp_a [4];
        logic         exp_c [4];
        logic         seen;

        exp_a = '{4'h1, 4'h0, 4'h0, 4'h0};
        exp_c = '{1'b0, 1'b1, 1'b1, 1'b1};

        vt.push_back('{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0});
        vt.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
        vt.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
        vt.push_back('{16'h5A5A, 16'hA5A5, 1'b1, 1'b0, 16'h0000, 1'b1});
        vt.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
        vt.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
        vt.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0});
`ifdef RCA_SEQ_SUB_EN
        vt.push_back('{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1});
        vt.push_back('{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0});
        vt.push_back('{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0});
`endif

        // Power-on reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 0);
        chk("reset busy", 64'(busy), 0);
        chk("reset sum", 64'(sum), 0);
        chk("reset cout", 64'(cout), 0);
        chk("reset in_ready", 64'(in_ready), 0);
        chk("reset add_a", 64'(add_a), 0);
        chk("reset add_b", 64'(add_b), 0);
        chk("reset add_cin", 64'(add_cin), 0);
        rst_n = 1'b1;
        #1;
        chk("in_ready after release", 64'(in_ready), 1);

        // Directed vectors
        foreach (vt[i]) begin
            op(vt[i].va, vt[i].vb, vt[i].vc, vt[i].vs, $sformatf("vec%0d", i), rs, rc);
            chk($sformatf("vec%0d sum", i), 64'(rs), 64'(vt[i].es));
            chk($sformatf("vec%0d cout", i), 64'(rc), 64'(vt[i].ec));
            if (i == 0)
                for (int j = 0; j < 4; j++)
                    chk($sformatf("vec0 add_a[%0d]", j), 64'(seq_a[j]), 64'(exp_a[j]));
            if (i == 1)
                for (int j = 0; j < 4; j++)
                    chk($sformatf("vec1 add_cin[%0d]", j), 64'(seq_c[j]), 64'(exp_c[j]));
        end

        // Backpressure in DONE with in_valid/a toggling
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (NIB) @(negedge clk);
        chk("bp out_valid", 64'(out_valid), 1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = W'($urandom);
            in_valid = ~in_valid;
            @(negedge clk);
            if (sum !== 16'h3333 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
                seen = 1'b1;
        end
        chk("bp held stable", 64'(seen), 0);
        a = 16'h0100; b = 16'h0010; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp handshake out_valid", 64'(out_valid), 0);
        chk("bp no accept from DONE", 64'(busy), 0);
        chk("bp in_ready after handshake", 64'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp next accepted", 64'(busy), 1);
        repeat (NIB) @(negedge clk);
        chk("bp next out_valid", 64'(out_valid), 1);
        chk("bp next sum", 64'(sum), 64'(16'h0110));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset mid-RUN discards the operation
        a = 16'h00F7; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun in_ready during reset", 64'(in_ready), 0);
        @(negedge clk);
        chk("midrun out_valid", 64'(out_valid), 0);
        chk("midrun sum", 64'(sum), 0);
        chk("midrun cout", 64'(cout), 0);
        chk("midrun busy", 64'(busy), 0);
        chk("midrun add_*", 64'({add_a, add_b, add_cin}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrun in_ready after release", 64'(in_ready), 1);
        seen = 1'b0;
        for (int i = 0; i < NIB + 2; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrun no stale out_valid", 64'(seen), 0);

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic         rcin, rsub;
            ra   = W'($urandom);
            rb   = W'($urandom);
            rcin = 1'($urandom_range(0, 1));
            rsub = 1'($urandom_range(0, 1));
            exp  = model(ra, rb, rcin, rsub);
            op(ra, rb, rcin, rsub, $sformatf("rnd%0d", i), rs, rc);
            chk($sformatf("rnd%0d sum", i), 64'(rs), 64'(exp[W-1:0]));
            chk($sformatf("rnd%0d cout", i), 64'(rc), 64'(exp[W]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
